// File: rtl/float_point_mult_issuer.sv
// float_point_mult_issuer: initiator for the float_point_multiplier_wrapper handshake.
// Operand pairs are queued in a small FIFO, issued one at a time to the wrapper, and each
// product is presented downstream on a valid/ready port in issue order.
// Optional feature macro: FP_MULT_TIMEOUT_EN (abort a WAIT that outlasts TIMEOUT_CYCLES).
module float_point_mult_issuer #(
    parameter int unsigned EXP_LEN        = 8,
    parameter int unsigned MANTISSA_LEN   = 23,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [EXP_LEN+MANTISSA_LEN:0]      in_a,
    input  logic [EXP_LEN+MANTISSA_LEN:0]      in_b,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [EXP_LEN+MANTISSA_LEN:0]      out_result,
    output logic [EXP_LEN+MANTISSA_LEN:0]      mult_inp_a,
    output logic [EXP_LEN+MANTISSA_LEN:0]      mult_inp_b,
    output logic                               mult_inp_data_ready,
    input  logic                               mult_out_product_ready,
    input  logic [EXP_LEN+MANTISSA_LEN:0]      mult_out_product,
    output logic [$clog2(FIFO_DEPTH):0]        fifo_count,
    output logic                               busy,
    output logic                               timeout_error
);

    localparam int unsigned W     = EXP_LEN + MANTISSA_LEN + 1;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
    } operand_pair_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    // Reject configurations the pointer arithmetic cannot support
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("float_point_mult_issuer: FIFO_DEPTH must be a power of 2 >= 2 and TIMEOUT_CYCLES >= 2");
    end

    state_t              state_q, state_d;
    operand_pair_t       mem_q [FIFO_DEPTH];
    operand_pair_t       mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                in_ready_q, in_ready_d;
    logic                busy_q, busy_d;
    logic [W-1:0]        mult_a_q, mult_a_d;
    logic [W-1:0]        mult_b_q, mult_b_d;
    logic                data_ready_q, data_ready_d;
    logic                out_valid_q, out_valid_d;
    logic [W-1:0]        out_result_q, out_result_d;

    logic                push_c;
    logic                pop_c;
    logic                capture_c;
    logic                accept_c;
    logic                abort_c;

    // Handshake events shared by the FSM and the datapath
    always_comb begin
        push_c    = in_valid && in_ready_q;
        pop_c     = (state_q == S_IDLE) && (count_q != '0);
        capture_c = (state_q == S_WAIT) && mult_out_product_ready;
        accept_c  = (state_q == S_HOLD) && out_ready;
    end

`ifdef FP_MULT_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
    logic            timeout_error_q, timeout_error_d;

    // WAIT watchdog: counter is zero on the first WAIT cycle, abort on the last allowed one
    always_comb begin
        abort_c         = (state_q == S_WAIT) && !mult_out_product_ready &&
                          (wait_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
        wait_cnt_d      = (state_q == S_WAIT) ? wait_cnt_q + TO_W'(1) : '0;
        timeout_error_d = timeout_error_q || abort_c;
    end

    // Watchdog registers; the error flag is sticky until reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt_q      <= '0;
            timeout_error_q <= 1'b0;
        end else begin
            wait_cnt_q      <= wait_cnt_d;
            timeout_error_q <= timeout_error_d;
        end
    end

    assign timeout_error = timeout_error_q;
`else
    // Without the watchdog a WAIT lasts until the wrapper answers
    always_comb begin
        abort_c = 1'b0;
    end

    assign timeout_error = 1'b0;
`endif

    // Operand FIFO: write on upstream handshake, read only when the FSM leaves IDLE
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_c) begin
            mem_d[wr_ptr_q] = '{a: in_a, b: in_b};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        in_ready_d = (count_d != CNT_W'(FIFO_DEPTH));
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (pop_c) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (capture_c) begin
                    state_d = S_HOLD;
                end else if (abort_c) begin
                    state_d = S_IDLE;
                end
            end
            S_HOLD: begin
                if (accept_c) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: operands load only on IDLE->ISSUE, product loads only on capture
    always_comb begin
        mult_a_d     = mult_a_q;
        mult_b_d     = mult_b_q;
        out_result_d = out_result_q;
        out_valid_d  = out_valid_q;
        data_ready_d = (state_d == S_ISSUE);
        busy_d       = (state_d != S_IDLE) || (count_d != '0);
        if (pop_c) begin
            mult_a_d = mem_q[rd_ptr_q].a;
            mult_b_d = mem_q[rd_ptr_q].b;
        end
        if (capture_c) begin
            out_result_d = mult_out_product;
            out_valid_d  = 1'b1;
        end
        if (accept_c) begin
            out_valid_d = 1'b0;
        end
    end

    // State, FIFO and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            mem_q        <= '{default: '0};
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            in_ready_q   <= 1'b1;
            busy_q       <= 1'b0;
            mult_a_q     <= '0;
            mult_b_q     <= '0;
            data_ready_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
        end else begin
            state_q      <= state_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            in_ready_q   <= in_ready_d;
            busy_q       <= busy_d;
            mult_a_q     <= mult_a_d;
            mult_b_q     <= mult_b_d;
            data_ready_q <= data_ready_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
        end
    end

    assign in_ready            = in_ready_q;
    assign fifo_count          = count_q;
    assign busy                = busy_q;
    assign mult_inp_a          = mult_a_q;
    assign mult_inp_b          = mult_b_q;
    assign mult_inp_data_ready = data_ready_q;
    assign out_valid           = out_valid_q;
    assign out_result          = out_result_q;

endmodule

// File: tb/tb_float_point_mult_issuer.sv
// Bench for float_point_mult_issuer: a behavioural multiplier-wrapper model answers each
// data_ready pulse after a random latency with a real-valued product, and a scoreboard
// of expected products (built from accepted upstream pairs) is compared in order.
module tb_float_point_mult_issuer;

    localparam int unsigned W       = 32;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 64;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_result;
    logic [W-1:0]  mult_inp_a;
    logic [W-1:0]  mult_inp_b;
    logic          mult_inp_data_ready;
    logic          mult_out_product_ready = 1'b0;
    logic [W-1:0]  mult_out_product = '0;
    logic [2:0]    fifo_count;
    logic          busy;
    logic          timeout_error;

    int checks = 0;
    int errors = 0;

    float_point_mult_issuer #(
        .EXP_LEN(8), .MANTISSA_LEN(23), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .mult_inp_a(mult_inp_a), .mult_inp_b(mult_inp_b),
        .mult_inp_data_ready(mult_inp_data_ready),
        .mult_out_product_ready(mult_out_product_ready),
        .mult_out_product(mult_out_product),
        .fifo_count(fifo_count), .busy(busy), .timeout_error(timeout_error)
    );

    always #5 clock = ~clock;

    // IEEE single multiply through double precision (normal operands only, truncated)
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] da, db, dp;
        real         r;
        int          e;
        da = {a[31], 11'(int'(a[30:23]) + 896), a[22:0], 29'b0};
        db = {b[31], 11'(int'(b[30:23]) + 896), b[22:0], 29'b0};
        r  = $bitstoreal(da) * $bitstoreal(db);
        dp = $realtobits(r);
        e  = int'(dp[62:52]) - 896;
        return {dp[63], 8'(e), dp[51:29]};
    endfunction

    function automatic logic [31:0] rand_op();
        return {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
    endfunction

    // Wrapper model
    bit           model_silent = 1'b0;
    int           lat_max = 3;
    bit           pending = 1'b0;
    int           lat_cnt = 0;
    logic [W-1:0] pa = '0;
    logic [W-1:0] pb = '0;
    int           stray_req = 0;
    int           stray_sent = 0;

    always @(negedge clock) begin
        mult_out_product_ready = 1'b0;
        if (reset) begin
            pending = 1'b0;
        end else begin
            if (stray_sent != stray_req) begin
                mult_out_product_ready = 1'b1;
                mult_out_product       = 32'hDEAD_BEEF;
                stray_sent++;
            end else if (pending) begin
                if (lat_cnt == 0) begin
                    mult_out_product_ready = 1'b1;
                    mult_out_product       = fmul(pa, pb);
                    pending                = 1'b0;
                end else begin
                    lat_cnt--;
                end
            end
            if (mult_inp_data_ready && !model_silent) begin
                pending = 1'b1;
                lat_cnt = $urandom_range(0, lat_max);
                pa      = mult_inp_a;
                pb      = mult_inp_b;
            end
        end
    end

    // Monitor and scoreboard collection
    logic [W-1:0] exp_q[$];
    logic [W-1:0] obs_q[$];
    int           dr_pulses = 0;
    int           dr_wide = 0;
    int           dr_overlap = 0;
    int           ab_glitch = 0;
    int           full_ready = 0;
    int           max_count = 0;
    int           ov_cycles = 0;
    logic         prev_dr = 1'b0;
    logic [W-1:0] prev_a = '0;
    logic [W-1:0] prev_b = '0;

    always @(negedge clock) begin
        if (reset) begin
            exp_q.delete();
        end else begin
            if (in_valid && in_ready) exp_q.push_back(fmul(in_a, in_b));
            if (out_valid && out_ready) obs_q.push_back(out_result);
            if (mult_inp_data_ready) dr_pulses++;
            if (mult_inp_data_ready && prev_dr) dr_wide++;
            if (mult_inp_data_ready && out_valid) dr_overlap++;
            if ((mult_inp_a !== prev_a || mult_inp_b !== prev_b) && !mult_inp_data_ready) ab_glitch++;
            if (int'(fifo_count) == DEPTH && in_ready) full_ready++;
            if (int'(fifo_count) > max_count) max_count = int'(fifo_count);
            if (out_valid) ov_cycles++;
        end
        prev_dr = mult_inp_data_ready;
        prev_a  = mult_inp_a;
        prev_b  = mult_inp_b;
    end

    // Present one pair; returns at posedge+1 right after it was accepted
    task automatic push_pair(input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        n        = 0;
        @(negedge clock);
        while (!in_ready && n < 500) begin
            n++;
            @(negedge clock);
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL push_accept: in_ready stuck at %0b, required 1", in_ready);
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        while (n < budget) begin
            @(negedge clock);
            n++;
            if (!busy && !out_valid && !in_valid && obs_q.size() == exp_q.size()) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic clear_stats();
        exp_q.delete();
        obs_q.delete();
        dr_wide    = 0;
        dr_overlap = 0;
        ab_glitch  = 0;
        full_ready = 0;
        max_count  = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #12;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
        checks++; if (mult_inp_data_ready !== 1'b0) begin errors++; $display("FAIL rst_data_ready: got %b required 0", mult_inp_data_ready); end
        checks++; if (mult_inp_a !== '0 || mult_inp_b !== '0) begin errors++; $display("FAIL rst_inp_ab: got %h/%h required 0/0", mult_inp_a, mult_inp_b); end
        checks++; if (out_result !== '0) begin errors++; $display("FAIL rst_out_result: got %h required 0", out_result); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rst_fifo_count: got %0d required 0", fifo_count); end
        checks++; if (busy !== 1'b0 || timeout_error !== 1'b0) begin errors++; $display("FAIL rst_busy_to: got %b/%b required 0/0", busy, timeout_error); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b required 1", in_ready); end
        @(negedge clock);
        #2;
        reset = 1'b0;
        @(posedge clock);
        #1;
        clear_stats();
    endtask

    task automatic test_single();
        int p0;
        bit ok;
        clear_stats();
        out_ready = 1'b1;
        lat_max   = 3;
        p0        = dr_pulses;
        push_pair(32'h4000_0000, 32'h4040_0000);
        wait_idle(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_done: idle=%b required 1", ok); end
        checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL single_count: got %0d results required 1", obs_q.size()); end
        else begin
            checks++; if (obs_q[0] !== 32'h40C0_0000) begin errors++; $display("FAIL single_result: got %h required 40c00000", obs_q[0]); end
        end
        checks++; if (dr_pulses - p0 != 1 || dr_wide != 0) begin errors++; $display("FAIL single_pulse: pulses %0d wide %0d required 1/0", dr_pulses - p0, dr_wide); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL single_fifo_count: got %0d required 0", fifo_count); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        clear_stats();
        out_ready = 1'b1;
        lat_max   = 4;
        for (int i = 0; i < 5; i++) push_pair(rand_op(), rand_op());
        wait_idle(500, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_done: idle=%b required 1", ok); end
        checks++; if (max_count != 4 || full_ready != 0) begin errors++; $display("FAIL b2b_full: max_count %0d ready_at_full %0d required 4/0", max_count, full_ready); end
        checks++; if (obs_q.size() != 5 || exp_q.size() != 5) begin errors++; $display("FAIL b2b_count: got %0d/%0d required 5", obs_q.size(), exp_q.size()); end
        else begin
            for (int i = 0; i < 5; i++) begin
                checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_result[%0d]: got %h required %h", i, obs_q[i], exp_q[i]); end
            end
        end
        checks++; if (dr_wide != 0 || dr_overlap != 0 || ab_glitch != 0) begin errors++; $display("FAIL b2b_protocol: wide %0d overlap %0d glitch %0d required 0", dr_wide, dr_overlap, ab_glitch); end
    endtask

    task automatic test_hold();
        int           p0, n, unstable;
        logic [W-1:0] r;
        bit           ok;
        clear_stats();
        out_ready = 1'b0;
        lat_max   = 2;
        push_pair(rand_op(), rand_op());
        push_pair(rand_op(), rand_op());
        n = 0;
        while (!out_valid && n < 100) begin @(negedge clock); n++; end
        checks++; if (!out_valid) begin errors++; $display("FAIL hold_valid: out_valid %b required 1", out_valid); end
        r        = out_result;
        p0       = dr_pulses;
        unstable = 0;
        repeat (10) begin
            @(negedge clock);
            if (out_result !== r || !out_valid) unstable++;
        end
        checks++; if (unstable != 0) begin errors++; $display("FAIL hold_stable: %0d unstable cycles required 0", unstable); end
        checks++; if (dr_pulses != p0) begin errors++; $display("FAIL hold_no_issue: %0d extra pulses required 0", dr_pulses - p0); end
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL hold_fifo_count: got %0d required 1", fifo_count); end
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        wait_idle(200, ok);
        checks++; if (obs_q.size() != 2 || exp_q.size() != 2) begin errors++; $display("FAIL hold_count: got %0d/%0d required 2", obs_q.size(), exp_q.size()); end
        else begin
            for (int i = 0; i < 2; i++) begin
                checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL hold_result[%0d]: got %h required %h", i, obs_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_push_pop_wrap();
        int n;
        bit ok;
        clear_stats();
        out_ready = 1'b0;
        lat_max   = 2;
        for (int i = 0; i < 3; i++) push_pair(rand_op(), rand_op());
        n = 0;
        while (!out_valid && n < 100) begin @(negedge clock); n++; end
        checks++; if (!out_valid || fifo_count !== 3'd2) begin errors++; $display("FAIL pp_setup: valid %b count %0d required 1/2", out_valid, fifo_count); end
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_a      = rand_op();
        in_b      = rand_op();
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL pp_same_cycle: count %0d required 2", fifo_count); end
        checks++; if (mult_inp_data_ready !== 1'b1) begin errors++; $display("FAIL pp_issue: data_ready %b required 1", mult_inp_data_ready); end
        out_ready = 1'b1;
        lat_max   = 3;
        for (int i = 0; i < 12; i++) begin
            push_pair(rand_op(), rand_op());
            repeat ($urandom_range(0, 2)) @(posedge clock);
            #1;
        end
        wait_idle(1000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL wrap_done: idle=%b required 1", ok); end
        checks++; if (obs_q.size() != 16 || exp_q.size() != 16) begin errors++; $display("FAIL wrap_count: got %0d/%0d required 16", obs_q.size(), exp_q.size()); end
        else begin
            for (int i = 0; i < 16; i++) begin
                checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL wrap_result[%0d]: got %h required %h", i, obs_q[i], exp_q[i]); end
            end
        end
        checks++; if (dr_wide != 0 || dr_overlap != 0 || ab_glitch != 0 || full_ready != 0) begin errors++; $display("FAIL wrap_protocol: wide %0d overlap %0d glitch %0d full %0d required 0", dr_wide, dr_overlap, ab_glitch, full_ready); end
    endtask

    task automatic test_reset_in_wait();
        int n, ov0;
        bit ok;
        clear_stats();
        out_ready    = 1'b1;
        model_silent = 1'b1;
        push_pair(rand_op(), rand_op());
        n = 0;
        while (!mult_inp_data_ready && n < 50) begin @(negedge clock); n++; end
        repeat (3) @(negedge clock);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rw_busy_before: got %b required 1", busy); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || mult_inp_data_ready !== 1'b0) begin errors++; $display("FAIL rw_ctrl: valid %b data_ready %b required 0/0", out_valid, mult_inp_data_ready); end
        checks++; if (mult_inp_a !== '0 || mult_inp_b !== '0 || out_result !== '0) begin errors++; $display("FAIL rw_data: a %h b %h r %h required 0", mult_inp_a, mult_inp_b, out_result); end
        checks++; if (busy !== 1'b0 || fifo_count !== 3'd0) begin errors++; $display("FAIL rw_state: busy %b count %0d required 0/0", busy, fifo_count); end
        @(negedge clock);
        #2;
        reset = 1'b0;
        clear_stats();
        model_silent = 1'b0;
        ov0 = ov_cycles;
        stray_req++;
        repeat (10) @(negedge clock);
        checks++; if (ov_cycles != ov0 || busy !== 1'b0) begin errors++; $display("FAIL rw_stray: out_valid cycles %0d busy %b required 0/0", ov_cycles - ov0, busy); end
        @(posedge clock);
        #1;
        push_pair(32'h3FC0_0000, 32'h4080_0000);
        wait_idle(200, ok);
        checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL rw_recover_count: got %0d required 1", obs_q.size()); end
        else begin
            checks++; if (obs_q[0] !== 32'h40C0_0000) begin errors++; $display("FAIL rw_recover: got %h required 40c00000", obs_q[0]); end
        end
    endtask

`ifdef FP_MULT_TIMEOUT_EN
    task automatic test_timeout();
        int n, ov0;
        bit ok;
        clear_stats();
        out_ready    = 1'b1;
        model_silent = 1'b1;
        ov0          = ov_cycles;
        push_pair(rand_op(), rand_op());
        n = 0;
        while (!mult_inp_data_ready && n < 50) begin @(negedge clock); n++; end
        n = 0;
        while (n < 300) begin
            @(negedge clock);
            n++;
            if (timeout_error) break;
        end
        checks++; if (n != TIMEOUT + 1) begin errors++; $display("FAIL to_latency: flag after %0d cycles required %0d", n, TIMEOUT + 1); end
        checks++; if (ov_cycles != ov0 || busy !== 1'b0) begin errors++; $display("FAIL to_drop: out_valid cycles %0d busy %b required 0/0", ov_cycles - ov0, busy); end
        model_silent = 1'b0;
        stray_req++;
        repeat (5) @(negedge clock);
        @(posedge clock);
        #1;
        clear_stats();
        push_pair(32'h4000_0000, 32'h4040_0000);
        wait_idle(200, ok);
        checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL to_next_count: got %0d required 1", obs_q.size()); end
        else begin
            checks++; if (obs_q[0] !== 32'h40C0_0000) begin errors++; $display("FAIL to_next: got %h required 40c00000", obs_q[0]); end
        end
        checks++; if (timeout_error !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b required 1", timeout_error); end
    endtask
`else
    task automatic test_no_timeout();
        int ov0;
        clear_stats();
        out_ready    = 1'b1;
        model_silent = 1'b1;
        ov0          = ov_cycles;
        push_pair(rand_op(), rand_op());
        repeat (150) @(negedge clock);
        checks++; if (busy !== 1'b1 || timeout_error !== 1'b0 || ov_cycles != ov0) begin errors++; $display("FAIL nto_wait: busy %b flag %b valid cycles %0d required 1/0/0", busy, timeout_error, ov_cycles - ov0); end
        model_silent = 1'b0;
        test_reset();
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_hold();
        test_push_pop_wrap();
        test_reset_in_wait();
`ifdef FP_MULT_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
